// File: rtl/prbs_rate_ctrl.sv
// Sequencing controller for the PRBS core LFSR: PN-select settling, divided bit-rate
// enable generation, burst/continuous runs, delayed bit capture and sequence counting.
module prbs_rate_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PN_MAX_CODE   = 9,
  parameter int CORE_LAT      = 1
) (
  input  logic        dac_clk,
  input  logic        reset_n,
  input  logic        cfg_start,
  input  logic        cfg_stop,
  input  logic [3:0]  cfg_pn_select,
  input  logic [15:0] cfg_rate_div,
  input  logic [15:0] cfg_burst_len,
  input  logic        prbs_bit_in,
  input  logic        seq_done_in,
  output logic        lfsr_clk_enable,
  output logic [3:0]  prbs_pn_select_reg,
  output logic        bit_strobe,
  output logic        bit_q,
  output logic        busy,
  output logic        burst_done,
  output logic        cfg_err,
  output logic [15:0] seq_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [4:0] PN_MAX      = 5'(PN_MAX_CODE);

  state_t      state_reg, state_next;
  logic [3:0]  pn_select_reg, pn_select_next;
  logic [15:0] rate_div_reg, rate_div_next;
  logic [15:0] burst_len_reg, burst_len_next;
  logic [15:0] div_cnt_reg, div_cnt_next;
  logic [15:0] bit_cnt_reg, bit_cnt_next;
  logic [3:0]  settle_cnt_reg, settle_cnt_next;
  logic [15:0] seq_cnt_reg, seq_cnt_next;
  logic        enable_reg, enable_next;
  logic        burst_done_reg, burst_done_next;
  logic        cfg_err_reg, cfg_err_next;
  logic        seq_done_d_reg;
  logic        strobe_reg;
  logic        bit_q_reg;
  logic        seq_rise;

  logic [CORE_LAT-1:0] en_pipe_reg, en_pipe_next;

  assign seq_rise = seq_done_in & ~seq_done_d_reg;

  always_comb begin
    state_next      = state_reg;
    pn_select_next  = pn_select_reg;
    rate_div_next   = rate_div_reg;
    burst_len_next  = burst_len_reg;
    div_cnt_next    = div_cnt_reg;
    bit_cnt_next    = bit_cnt_reg;
    settle_cnt_next = settle_cnt_reg;
    seq_cnt_next    = seq_cnt_reg;
    enable_next     = 1'b0;
    burst_done_next = 1'b0;
    cfg_err_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (cfg_start && !cfg_stop) begin
          if ({1'b0, cfg_pn_select} > PN_MAX) begin
            cfg_err_next = 1'b1;
          end else begin
            pn_select_next  = cfg_pn_select;
            rate_div_next   = cfg_rate_div;
            burst_len_next  = cfg_burst_len;
            bit_cnt_next    = 16'd0;
            seq_cnt_next    = 16'd0;
            settle_cnt_next = 4'd0;
            div_cnt_next    = 16'd0;
            state_next      = LOAD;
          end
        end
      end
      LOAD: begin
        if (cfg_stop) begin
          state_next = IDLE;
        end else if (settle_cnt_reg == SETTLE_LAST) begin
          div_cnt_next = 16'd0;
          state_next   = RUN;
        end else begin
          settle_cnt_next = settle_cnt_reg + 4'd1;
        end
      end
      RUN: begin
        // Stop outranks burst completion; the final enable has already been issued.
        if (cfg_stop) begin
          state_next = IDLE;
        end else if (burst_len_reg != 16'd0 && bit_cnt_reg == burst_len_reg) begin
          burst_done_next = 1'b1;
          state_next      = DONE;
        end else if (div_cnt_reg == 16'd0) begin
          enable_next  = 1'b1;
          div_cnt_next = rate_div_reg;
          bit_cnt_next = bit_cnt_reg + 16'd1;
        end else begin
          div_cnt_next = div_cnt_reg - 16'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (state_reg == RUN && seq_rise && seq_cnt_reg != 16'hFFFF) begin
      seq_cnt_next = seq_cnt_reg + 16'd1;
    end
  end

  // Enable delay line: the tap at CORE_LAT-1 marks when the core output is fresh.
  generate
    assign en_pipe_next[0] = enable_reg;
    for (genvar gi = 1; gi < CORE_LAT; gi++) begin : g_pipe
      assign en_pipe_next[gi] = en_pipe_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge dac_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      pn_select_reg  <= 4'd0;
      rate_div_reg   <= 16'd0;
      burst_len_reg  <= 16'd0;
      div_cnt_reg    <= 16'd0;
      bit_cnt_reg    <= 16'd0;
      settle_cnt_reg <= 4'd0;
      seq_cnt_reg    <= 16'd0;
      enable_reg     <= 1'b0;
      burst_done_reg <= 1'b0;
      cfg_err_reg    <= 1'b0;
      seq_done_d_reg <= 1'b0;
      en_pipe_reg    <= '0;
      strobe_reg     <= 1'b0;
      bit_q_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pn_select_reg  <= pn_select_next;
      rate_div_reg   <= rate_div_next;
      burst_len_reg  <= burst_len_next;
      div_cnt_reg    <= div_cnt_next;
      bit_cnt_reg    <= bit_cnt_next;
      settle_cnt_reg <= settle_cnt_next;
      seq_cnt_reg    <= seq_cnt_next;
      enable_reg     <= enable_next;
      burst_done_reg <= burst_done_next;
      cfg_err_reg    <= cfg_err_next;
      seq_done_d_reg <= seq_done_in;
      en_pipe_reg    <= en_pipe_next;
      strobe_reg     <= en_pipe_reg[CORE_LAT-1];
      if (en_pipe_reg[CORE_LAT-1]) begin
        bit_q_reg <= prbs_bit_in;
      end
    end
  end

  assign lfsr_clk_enable    = enable_reg;
  assign prbs_pn_select_reg = pn_select_reg;
  assign bit_strobe         = strobe_reg;
  assign bit_q              = bit_q_reg;
  assign busy               = (state_reg != IDLE);
  assign burst_done         = burst_done_reg;
  assign cfg_err            = cfg_err_reg;
  assign seq_cnt            = seq_cnt_reg;

endmodule

// File: tb/tb_prbs_rate_ctrl.sv
// Bench for prbs_rate_ctrl: per-cycle logs compared against an event-time model of
// enables, strobes, burst_done and busy derived from start/stop edges and N/burst length.
module tb_prbs_rate_ctrl;

  localparam int SETTLE = 2;
  localparam int CL     = 1;
  localparam int LOGN   = 8192;
  localparam int NONE   = 32'h7fff_ffff;

  logic        dac_clk;
  logic        reset_n;
  logic        cfg_start;
  logic        cfg_stop;
  logic [3:0]  cfg_pn_select;
  logic [15:0] cfg_rate_div;
  logic [15:0] cfg_burst_len;
  logic        prbs_bit_in;
  logic        seq_done_in;
  logic        lfsr_clk_enable;
  logic [3:0]  prbs_pn_select_reg;
  logic        bit_strobe;
  logic        bit_q;
  logic        busy;
  logic        burst_done;
  logic        cfg_err;
  logic [15:0] seq_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  bit en_log[LOGN], stb_log[LOGN], bitq_log[LOGN], pin_log[LOGN];
  bit done_log[LOGN], busy_log[LOGN], err_log[LOGN];
  bit exp_en[LOGN], exp_stb[LOGN], exp_done[LOGN], exp_busy[LOGN];

  prbs_rate_ctrl #(.SETTLE_CYCLES(SETTLE), .PN_MAX_CODE(9), .CORE_LAT(CL)) dut (
    .dac_clk(dac_clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_pn_select(cfg_pn_select), .cfg_rate_div(cfg_rate_div), .cfg_burst_len(cfg_burst_len),
    .prbs_bit_in(prbs_bit_in), .seq_done_in(seq_done_in), .lfsr_clk_enable(lfsr_clk_enable),
    .prbs_pn_select_reg(prbs_pn_select_reg), .bit_strobe(bit_strobe), .bit_q(bit_q),
    .busy(busy), .burst_done(burst_done), .cfg_err(cfg_err), .seq_cnt(seq_cnt)
  );

  initial begin
    dac_clk = 1'b0;
    forever #5 dac_clk = ~dac_clk;
  end

  always @(posedge dac_clk) cyc = cyc + 1;

  always @(negedge dac_clk) begin
    if (cyc < LOGN) begin
      en_log[cyc]   = lfsr_clk_enable;
      stb_log[cyc]  = bit_strobe;
      bitq_log[cyc] = bit_q;
      pin_log[cyc]  = prbs_bit_in;
      done_log[cyc] = burst_done;
      busy_log[cyc] = busy;
      err_log[cyc]  = cfg_err;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge dac_clk);
    #1;
    prbs_bit_in = 1'($urandom_range(0, 1));
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  // Expected behaviour of one accepted start at edge e0; returns the first IDLE cycle.
  task automatic plan(input int e0, input int n, input int l, input int stop_edge, output int idle);
    int t, k, last;
    bit completed;
    for (int c = e0; c < e0 + 1024 && c < LOGN; c++) begin
      exp_en[c] = 0; exp_stb[c] = 0; exp_done[c] = 0; exp_busy[c] = 0;
    end
    t = e0 + SETTLE + 1;
    k = 0;
    last = -1;
    while ((l == 0 || k < l) && t < stop_edge && t < LOGN - 8) begin
      exp_en[t] = 1;
      exp_stb[t + CL + 1] = 1;
      last = t;
      k++;
      t += n + 1;
    end
    completed = (l != 0) && (k == l) && (last + 1 < stop_edge);
    if (completed) begin
      exp_done[last + 1] = 1;
      idle = last + 2;
    end else begin
      idle = stop_edge;
    end
    for (int c = e0; c < idle; c++) exp_busy[c] = 1;
  endtask

  task automatic check_window(input int from, input int to, input string tag);
    int bad_en = 0, bad_stb = 0, bad_done = 0, bad_busy = 0, bad_bit = 0, bad_err = 0;
    int n_en = 0, n_stb = 0;
    for (int c = from; c <= to; c++) begin
      if (en_log[c] !== exp_en[c]) bad_en++;
      if (stb_log[c] !== exp_stb[c]) bad_stb++;
      if (done_log[c] !== exp_done[c]) bad_done++;
      if (busy_log[c] !== exp_busy[c]) bad_busy++;
      if (err_log[c] !== 1'b0) bad_err++;
      if (exp_stb[c] && bitq_log[c] !== pin_log[c-1]) bad_bit++;
      if (exp_en[c]) n_en++;
      if (stb_log[c]) n_stb++;
    end
    chk({tag, "_enable_bad_cycles"}, bad_en, 0);
    chk({tag, "_strobe_bad_cycles"}, bad_stb, 0);
    chk({tag, "_burst_done_bad_cycles"}, bad_done, 0);
    chk({tag, "_busy_bad_cycles"}, bad_busy, 0);
    chk({tag, "_cfg_err_bad_cycles"}, bad_err, 0);
    chk({tag, "_bit_q_bad_captures"}, bad_bit, 0);
    chk({tag, "_strobe_count"}, n_stb, n_en);
    $display("burst %s cycles %0d..%0d enables=%0d strobes=%0d", tag, from, to, n_en, n_stb);
  endtask

  task automatic run_burst(input logic [3:0] pn, input int n, input int l, input int stop_after,
                           input string tag);
    int e0, stop_edge, idle;
    cfg_pn_select = pn;
    cfg_rate_div  = 16'(n);
    cfg_burst_len = 16'(l);
    cfg_start     = 1'b1;
    e0 = cyc + 1;
    step();
    cfg_start = 1'b0;
    chk({tag, "_pn_select"}, prbs_pn_select_reg, pn);
    chk({tag, "_busy_at_start"}, busy, 1);
    if (stop_after > 0) begin
      goto(e0 + stop_after);
      cfg_stop = 1'b1;
      stop_edge = e0 + stop_after + 1;
      step();
      cfg_stop = 1'b0;
    end else begin
      stop_edge = NONE;
    end
    plan(e0, n, l, stop_edge, idle);
    goto(idle + CL + 3);
    check_window(e0, cyc - 1, tag);
  endtask

  initial begin
    int e0, e0b, idle, idle2;
    logic [3:0] last_pn;
    reset_n = 1'b1; cfg_start = 1'b0; cfg_stop = 1'b0; cfg_pn_select = 4'd0;
    cfg_rate_div = 16'd0; cfg_burst_len = 16'd0; prbs_bit_in = 1'b0; seq_done_in = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) step();
    chk("reset_enable", lfsr_clk_enable, 0);
    chk("reset_pn_select", prbs_pn_select_reg, 0);
    chk("reset_busy", busy, 0);
    chk("reset_strobe_bitq_done_err", {bit_strobe, bit_q, burst_done, cfg_err}, 0);
    chk("reset_seq_cnt", seq_cnt, 0);
    reset_n = 1'b1;
    repeat (2) step();

    run_burst(4'd0, 3, 8, 0, "directed_n3_b8");
    last_pn = 4'd0;

    for (int i = 0; i < 4; i++) begin
      logic [3:0] pn;
      int n, l, sa;
      pn = 4'($urandom_range(0, 9));
      n  = int'($urandom_range(0, 5));
      l  = int'($urandom_range(1, 10));
      sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : 0;
      run_burst(pn, n, l, sa, $sformatf("rand%0d_pn%0d_n%0d_b%0d_stop%0d", i, pn, n, l, sa));
      last_pn = pn;
    end

    run_burst(4'd1, 0, 0, 100, "continuous_stop");
    last_pn = 4'd1;

    // Rejected PN code
    cfg_pn_select = 4'd12; cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    chk("bad_pn_cfg_err", cfg_err, 1);
    chk("bad_pn_busy", busy, 0);
    chk("bad_pn_select_kept", prbs_pn_select_reg, last_pn);
    step();
    chk("bad_pn_cfg_err_single", cfg_err, 0);
    step();

    // seq_done edges: three in RUN, one in IDLE
    cfg_pn_select = 4'd2; cfg_rate_div = 16'd1; cfg_burst_len = 16'd20; cfg_start = 1'b1;
    e0 = cyc + 1;
    step();
    cfg_start = 1'b0;
    plan(e0, 1, 20, NONE, idle);
    for (int p = 1; p <= 3; p++) begin
      goto(e0 + 5 * p);
      seq_done_in = 1'b1;
      step();
      seq_done_in = 1'b0;
    end
    goto(idle + 2);
    seq_done_in = 1'b1;
    step();
    seq_done_in = 1'b0;
    goto(idle + 6);
    chk("seq_cnt_three", seq_cnt, 3);
    check_window(e0, cyc - 1, "seq_pulses");

    // Held start with config changed mid-burst, auto-restart
    cfg_pn_select = 4'd3; cfg_rate_div = 16'd2; cfg_burst_len = 16'd6; cfg_start = 1'b1;
    e0 = cyc + 1;
    step();
    plan(e0, 2, 6, NONE, idle);
    e0b = idle + 1;
    goto(e0 + 6);
    cfg_pn_select = 4'd5; cfg_rate_div = 16'd1; cfg_burst_len = 16'd4;
    goto(e0 + 8);
    seq_done_in = 1'b1; step(); seq_done_in = 1'b0;
    goto(e0 + 12);
    seq_done_in = 1'b1; step(); seq_done_in = 1'b0;
    goto(e0 + 14);
    chk("midburst_pn_kept", prbs_pn_select_reg, 3);
    goto(idle);
    chk("held_seq_cnt_before_restart", seq_cnt, 2);
    chk("held_idle_gap", busy, 0);
    goto(e0b);
    chk("restart_pn_select", prbs_pn_select_reg, 5);
    chk("restart_seq_cnt_cleared", seq_cnt, 0);
    chk("restart_busy", busy, 1);
    cfg_start = 1'b0;
    plan(e0b, 1, 4, NONE, idle2);
    goto(idle2 + CL + 3);
    check_window(e0, cyc - 1, "held_restart");

    // Asynchronous reset mid-run
    cfg_pn_select = 4'd4; cfg_rate_div = 16'd0; cfg_burst_len = 16'd0; cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    repeat (10) step();
    chk("pre_reset_strobe_active", bit_strobe, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_enable", lfsr_clk_enable, 0);
    chk("async_reset_pn_select", prbs_pn_select_reg, 0);
    chk("async_reset_busy", busy, 0);
    chk("async_reset_strobe_bitq_done_err", {bit_strobe, bit_q, burst_done, cfg_err}, 0);
    chk("async_reset_seq_cnt", seq_cnt, 0);
    step();
    reset_n = 1'b1;
    step();
    chk("after_reset_busy", busy, 0);

    // Start together with stop in IDLE
    cfg_pn_select = 4'd2; cfg_start = 1'b1; cfg_stop = 1'b1;
    step();
    chk("start_stop_busy", busy, 0);
    chk("start_stop_cfg_err", cfg_err, 0);
    step();
    cfg_start = 1'b0; cfg_stop = 1'b0;
    chk("start_stop_busy_later", busy, 0);
    chk("start_stop_pn_unchanged", prbs_pn_select_reg, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
